tdm_demux_1_8: RTL and testbench

TDM_DEMUX_1_8 -- requirements
Module: tdm_demux_1_8

---
 rtl/tdm_demux_1_8.sv | 115 +++++++++++
 tb/tb_tdm_demux_1_8.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_1_8.sv
// 1:8 TDM demultiplexer: collects an 8-slot frame framed by in_sync and presents it on y0..y7.
// Optional frame counter output frame_cnt is enabled by defining TDM_DEMUX_FRAME_CNT_EN.
//
// state | meaning
// HUNT  | waiting for a synced word to start a frame
// RUN   | inside a frame, r_slot is the next slot to fill
module tdm_demux_1_8 #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sync,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [WIDTH-1:0] y4,
    output logic [WIDTH-1:0] y5,
    output logic [WIDTH-1:0] y6,
    output logic [WIDTH-1:0] y7,
    output logic             frame_valid,
    output logic [2:0]       slot,
    output logic             sync_err
`ifdef TDM_DEMUX_FRAME_CNT_EN
    ,
    output logic [7:0]       frame_cnt
`endif
);

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [2:0]       r_slot;
    logic [WIDTH-1:0] r_shadow [0:6];
    logic [WIDTH-1:0] r_y      [0:7];
    logic             r_frame_valid;
    logic             r_sync_err;
`ifdef TDM_DEMUX_FRAME_CNT_EN
    logic [7:0]       r_frame_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= HUNT;
            r_slot        <= 3'd0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            for (int i = 0; i < 7; i++) r_shadow[i] <= '0;
            for (int i = 0; i < 8; i++) r_y[i] <= '0;
`ifdef TDM_DEMUX_FRAME_CNT_EN
            r_frame_cnt   <= 8'd0;
`endif
        end else begin
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            if (in_valid) begin
                case (r_state)
                    HUNT: begin
                        if (in_sync) begin
                            r_shadow[0] <= d;
                            r_slot      <= 3'd1;
                            r_state     <= RUN;
                        end
                    end
                    RUN: begin
                        if (in_sync) begin
                            // a sync anywhere but slot 0 aborts the partial frame
                            if (r_slot != 3'd0) r_sync_err <= 1'b1;
                            r_shadow[0] <= d;
                            r_slot      <= 3'd1;
                        end else if (r_slot == 3'd0) begin
                            r_sync_err <= 1'b1;
                            r_state    <= HUNT;
                        end else if (r_slot == 3'd7) begin
                            for (int i = 0; i < 7; i++) r_y[i] <= r_shadow[i];
                            r_y[7]        <= d;
                            r_frame_valid <= 1'b1;
                            r_slot        <= 3'd0;
`ifdef TDM_DEMUX_FRAME_CNT_EN
                            r_frame_cnt   <= r_frame_cnt + 8'd1;
`endif
                        end else begin
                            for (int i = 1; i < 7; i++) begin
                                if (r_slot == 3'(i)) r_shadow[i] <= d;
                            end
                            r_slot <= r_slot + 3'd1;
                        end
                    end
                    default: r_state <= HUNT;
                endcase
            end
        end
    end

    assign y0          = r_y[0];
    assign y1          = r_y[1];
    assign y2          = r_y[2];
    assign y3          = r_y[3];
    assign y4          = r_y[4];
    assign y5          = r_y[5];
    assign y6          = r_y[6];
    assign y7          = r_y[7];
    assign frame_valid = r_frame_valid;
    assign sync_err    = r_sync_err;
    assign slot        = r_slot;
`ifdef TDM_DEMUX_FRAME_CNT_EN
    assign frame_cnt   = r_frame_cnt;
`endif

endmodule

// File: tb/tb_tdm_demux_1_8.sv
// Randomized self-checking bench for tdm_demux_1_8 against a queue-based frame model.
// Define TDM_DEMUX_FRAME_CNT_EN to also exercise the frame counter.
module tb_tdm_demux_1_8;

    localparam int WIDTH = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_sync = 1'b0;
    logic [WIDTH-1:0] d = '0;
    logic [WIDTH-1:0] y0, y1, y2, y3, y4, y5, y6, y7;
    logic             frame_valid;
    logic [2:0]       slot;
    logic             sync_err;
`ifdef TDM_DEMUX_FRAME_CNT_EN
    logic [7:0]       frame_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tdm_demux_1_8 #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sync    (in_sync),
        .d          (d),
        .y0         (y0),
        .y1         (y1),
        .y2         (y2),
        .y3         (y3),
        .y4         (y4),
        .y5         (y5),
        .y6         (y6),
        .y7         (y7),
        .frame_valid(frame_valid),
        .slot       (slot),
        .sync_err   (sync_err)
`ifdef TDM_DEMUX_FRAME_CNT_EN
        ,
        .frame_cnt  (frame_cnt)
`endif
    );

    // Reference model: a frame is just the list of words collected since the last sync.
    bit               m_in_frame;
    logic [WIDTH-1:0] m_buf[$];
    logic [WIDTH-1:0] m_y[8];
    bit               m_fv;
    bit               m_err;
    int               m_frames;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] y_obs();
        return 32'({y0, y1, y2, y3, y4, y5, y6, y7});
    endfunction

    function automatic logic [31:0] y_exp();
        return 32'({m_y[0], m_y[1], m_y[2], m_y[3], m_y[4], m_y[5], m_y[6], m_y[7]});
    endfunction

    task automatic model_reset();
        m_in_frame = 0;
        m_buf.delete();
        for (int i = 0; i < 8; i++) m_y[i] = '0;
        m_fv = 0;
        m_err = 0;
        m_frames = 0;
    endtask

    task automatic model_cycle(input bit v, input bit s, input logic [WIDTH-1:0] w);
        m_fv = 0;
        m_err = 0;
        if (v) begin
            if (s) begin
                m_err = m_in_frame && (m_buf.size() != 0);
                m_buf.delete();
                m_buf.push_back(w);
                m_in_frame = 1;
            end else if (m_in_frame) begin
                if (m_buf.size() == 0) begin
                    m_err = 1;
                    m_in_frame = 0;
                end else begin
                    m_buf.push_back(w);
                    if (m_buf.size() == 8) begin
                        for (int i = 0; i < 8; i++) m_y[i] = m_buf[i];
                        m_buf.delete();
                        m_fv = 1;
                        m_frames++;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        check("y", y_obs(), y_exp());
        check("frame_valid", 32'(frame_valid), 32'(m_fv));
        check("sync_err", 32'(sync_err), 32'(m_err));
        check("slot", 32'(slot), 32'(m_buf.size()));
`ifdef TDM_DEMUX_FRAME_CNT_EN
        check("frame_cnt", 32'(frame_cnt), 32'(m_frames % 256));
`endif
    endtask

    task automatic step(input bit v, input bit s, input logic [WIDTH-1:0] w);
        @(negedge clk);
        in_valid = v;
        in_sync  = s;
        d        = w;
        @(posedge clk);
        model_cycle(v, s, w);
        #1 compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, $urandom_range(0, 1), WIDTH'($urandom));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input int maxgap);
        for (int k = 0; k < 8; k++) begin
            idle($urandom_range(0, maxgap));
            step(1, k == 0, WIDTH'($urandom));
        end
    endtask

    initial begin
        model_reset();
        #1 compare_all();
        do_reset();

        // words 1..7,0 back to back, sync on the first
        for (int k = 0; k < 8; k++) step(1, k == 0, WIDTH'((k + 1) % 8));
        check("basic_y", y_obs(), 32'({3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0}));
        check("basic_fv", 32'(frame_valid), 32'd1);
        check("basic_slot", 32'(slot), 32'd0);
        idle(1);
        check("basic_fv_drop", 32'(frame_valid), 32'd0);

        // unsynced words while hunting are ignored
        do_reset();
        for (int k = 0; k < 3; k++) step(1, 0, 3'd5);
        check("hunt_slot", 32'(slot), 32'd0);
        for (int k = 0; k < 8; k++) step(1, k == 0, WIDTH'(7 - k));
        check("hunt_y", y_obs(), 32'({3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}));

        // sync at slot 4 aborts the partial frame
        for (int k = 0; k < 4; k++) step(1, k == 0, 3'd2);
        step(1, 1, 3'd3);
        check("midsync_err", 32'(sync_err), 32'd1);
        check("midsync_y", y_obs(), 32'({3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}));
        for (int k = 1; k < 8; k++) step(1, 0, WIDTH'(k));
        check("midsync_newframe", y_obs(), 32'({3'd3, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}));

        // missing sync after a complete frame drops back to hunting
        step(1, 0, 3'd5);
        check("nosync_err", 32'(sync_err), 32'd1);
        step(1, 0, 3'd6);
        check("nosync_hold", y_obs(), 32'({3'd3, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}));

        // gaps between slots, then reset mid-frame at slot 5
        for (int r = 0; r < 4; r++) send_frame(3);
        for (int k = 0; k < 5; k++) step(1, k == 0, WIDTH'($urandom));
        check("pre_reset_slot", 32'(slot), 32'd5);
        do_reset();
        check("reset_y", y_obs(), 32'd0);
        check("reset_slot", 32'(slot), 32'd0);
        step(1, 0, 3'd4);
        check("post_reset_hunt", 32'(slot), 32'd0);

        // randomized traffic, syncs mostly but not always well placed
        for (int n = 0; n < 1500; n++) begin
            bit s;
            if (m_buf.size() == 0) s = ($urandom_range(0, 9) != 0);
            else s = ($urandom_range(0, 19) == 0);
            idle($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
            step(1, s, WIDTH'($urandom));
        end

`ifdef TDM_DEMUX_FRAME_CNT_EN
        do_reset();
        for (int f = 0; f < 257; f++) send_frame(0);
        check("frame_cnt_wrap", 32'(frame_cnt), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
